// File: rtl/clock_divider_prog.sv
// Runtime-programmable glitch-free clock divider.
// Generates a registered divided clock (clk_o) and a one-cycle tick_o strobe
// from clk_i. The divisor N is loadable at runtime. Divisor changes and
// start/stop requests only take effect at period boundaries, which are the
// edges where clk_o rises.
// Each period has ceil(N/2) high cycles followed by floor(N/2) low cycles.
//
// Handshake note: div_load_i is a single-cycle strobe with no back-pressure.
// div_i is captured on every edge where div_load_i is high, and the last
// capture before a boundary wins. en_i is a level request sampled on every
// edge.
module clock_divider_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             div_load_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             running_o,
  output logic             pending_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;    // position inside the current period
  logic [WIDTH-1:0] div_q, div_d;    // divisor of the period in progress
  logic [WIDTH-1:0] pval_q, pval_d;  // divisor waiting for the next boundary
  logic             pend_q, pend_d;
  logic             clk_d, tick_d;

  logic [WIDTH-1:0] div_clamped;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH:0]   high_len;
  logic             last_cycle;

  // Divisors 0 and 1 cannot form a period, so they are treated as 2.
  assign div_clamped = (div_i < MIN_DIV) ? MIN_DIV : div_i;
  assign cnt_inc     = cnt_q + WIDTH'(1);
  // The extra bit keeps ceil(N/2) exact for N = 2^WIDTH-1.
  assign high_len    = ({1'b0, div_q} + (WIDTH+1)'(1)) >> 1;
  assign last_cycle  = (cnt_q == (div_q - WIDTH'(1)));

  // Next-state, counter, divisor bookkeeping and the next output levels.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pval_d  = pval_q;
    pend_d  = pend_q;
    clk_d   = 1'b0;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Nothing is in progress, so a load takes effect immediately.
        if (div_load_i) begin
          div_d  = div_clamped;
          pval_d = div_clamped;
        end
        if (en_i) begin
          state_d = RUN;
          cnt_d   = '0;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end
      RUN, STOPPING: begin
        if (last_cycle) begin
          cnt_d = '0;
          if (en_i) begin
            // Boundary: start a new period using the pending divisor, if any.
            // A load on this same edge only affects the following boundary.
            state_d = RUN;
            clk_d   = 1'b1;
            tick_d  = 1'b1;
            if (pend_q) div_d = pval_q;
            pend_d = div_load_i;
            if (div_load_i) pval_d = div_clamped;
          end else begin
            // The period is complete. Go idle with the newest divisor applied.
            state_d = IDLE;
            pend_d  = 1'b0;
            if (div_load_i) begin
              div_d  = div_clamped;
              pval_d = div_clamped;
            end else if (pend_q) begin
              div_d = pval_q;
            end
          end
        end else begin
          // Mid-period: keep the phase. en_i only chooses whether this period
          // is the last one.
          cnt_d   = cnt_inc;
          state_d = en_i ? RUN : STOPPING;
          clk_d   = ({1'b0, cnt_inc} < high_len);
          if (div_load_i) begin
            pval_d = div_clamped;
            pend_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset clears everything without needing a clock edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DEF_DIV;
      pval_q  <= DEF_DIV;
      pend_q  <= 1'b0;
      clk_o   <= 1'b0;
      tick_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      clk_o   <= clk_d;
      tick_o  <= tick_d;
    end
  end

  assign running_o = (state_q != IDLE);
  assign pending_o = pend_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog. The reference model expands each period into
// its cycle-by-cycle {tick, clk} pattern in exp_q. It advances one entry per
// clk_i edge, and at every boundary it decides the next period from en_i and
// the divisor bookkeeping.
module tb_clock_divider_prog;
  localparam int WIDTH = 8;
  localparam int DEF   = 2;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             en_i  = 1'b0;
  logic [WIDTH-1:0] div_i = '0;
  logic             div_load_i = 1'b0;
  logic             clk_o, tick_o, running_o, pending_o;
  logic [1:0]       state_o;

  clock_divider_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .div_i(div_i),
    .div_load_i(div_load_i), .clk_o(clk_o), .tick_o(tick_o),
    .running_o(running_o), .pending_o(pending_o), .state_o(state_o)
  );

  // Clock.
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [1:0] exp_q[$];  // remaining cycles of the current period: {tick, clk}
  bit         m_run;
  int         m_div, m_pval;
  bit         m_pend;

  function automatic int clamp(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_run  = 0;
    m_div  = DEF;
    m_pval = DEF;
    m_pend = 0;
  endtask

  task automatic push_period(input int n);
    int h;
    h = (n + 1) / 2;
    for (int i = 0; i < n; i++) exp_q.push_back({(i == 0), (i < h)});
  endtask

  task automatic model_edge(input bit en, input bit ld, input int dv);
    if (!m_run) begin
      if (ld) begin
        m_div  = clamp(dv);
        m_pval = clamp(dv);
      end
      if (en) begin
        m_run = 1;
        push_period(m_div);
      end
    end else begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        if (m_pend) m_div = m_pval;
        m_pend = 0;
        if (ld) begin
          m_pval = clamp(dv);
          m_pend = 1;
        end
        if (en) begin
          push_period(m_div);
        end else begin
          m_run = 0;
          if (m_pend) m_div = m_pval;
          m_pend = 0;
        end
      end else if (ld) begin
        m_pval = clamp(dv);
        m_pend = 1;
      end
    end
  endtask

  task automatic compare_outputs();
    logic [1:0] e;
    e = m_run ? exp_q[0] : 2'b00;
    check("clk_o", clk_o, e[0]);
    check("tick_o", tick_o, e[1]);
    check("running_o", running_o, m_run);
    check("pending_o", pending_o, m_pend);
  endtask

  // Driver: one clk_i edge with the given inputs, then check the outputs just after it.
  task automatic step(input bit en, input bit ld, input int dv);
    en_i       = en;
    div_load_i = ld;
    div_i      = WIDTH'(dv);
    @(posedge clk_i);
    model_edge(en, ld, dv);
    #1;
    compare_outputs();
  endtask

  task automatic run(input int n, input bit en);
    repeat (n) step(en, 1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    en_i = 1'b0;
    div_load_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  int highs, ticks, r;

  initial begin
    model_reset();
    do_reset();
    check("reset_clk", clk_o, 1'b0);
    check("reset_tick", tick_o, 1'b0);
    check("reset_running", running_o, 1'b0);
    check("reset_pending", pending_o, 1'b0);

    // Default divisor 2 after reset.
    run(8, 1'b1);

    // Asynchronous reset while clk_o is high.
    while (clk_o !== 1'b1) step(1'b1, 1'b0, 0);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_clk", clk_o, 1'b0);
    check("async_rst_tick", tick_o, 1'b0);
    check("async_rst_running", running_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();

    // Odd divisor: load 5 together with enable from idle.
    step(1'b1, 1'b1, 5);
    run(20, 1'b1);

    // Mid-period reload: N=4, then load 7 two cycles after a boundary.
    run(6, 1'b0);
    step(1'b1, 1'b1, 4);
    run(5, 1'b1);
    step(1'b1, 1'b1, 7);
    run(12, 1'b1);
    // Two loads within one period: the last one wins.
    step(1'b1, 1'b1, 9);
    step(1'b1, 1'b1, 6);
    run(20, 1'b1);

    // Clamp: 0 and 1 behave as 2.
    step(1'b1, 1'b1, 0);
    run(12, 1'b1);
    step(1'b1, 1'b1, 1);
    run(8, 1'b1);

    // Maximum divisor: one full period has 128 high cycles and one tick.
    run(10, 1'b0);
    step(1'b1, 1'b1, 255);
    highs = 0;
    ticks = 0;
    for (int i = 0; i < 255; i++) begin
      highs += int'(clk_o);
      ticks += int'(tick_o);
      if (i < 254) step(1'b1, 1'b0, 0);
    end
    check("n255_high_cycles", highs, 128);
    check("n255_ticks", ticks, 1);
    run(260, 1'b0);

    // Graceful stop with N=6: drop en_i in the 2nd high cycle.
    step(1'b1, 1'b1, 6);
    step(1'b1, 1'b0, 0);
    run(10, 1'b0);
    check("stop_idle_clk", clk_o, 1'b0);
    check("stop_idle_running", running_o, 1'b0);
    // Restart, then request a stop and cancel it during the low phase.
    step(1'b1, 1'b0, 0);
    run(2, 1'b0);
    run(10, 1'b1);

    // Boundary collision: N=4, then load 3 on the edge where clk_o rises.
    run(8, 1'b0);
    step(1'b1, 1'b1, 4);
    run(3, 1'b1);
    step(1'b1, 1'b1, 3);
    run(12, 1'b1);

    // Randomized stimulus.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 3))
        0: step(r < 30, ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
        1: step(r < 95, ($urandom_range(0, 9) == 0), $urandom_range(0, 12));
        2: step(r < 97, ($urandom_range(0, 15) == 0), $urandom_range(0, 255));
        default: step(r < 90, ($urandom_range(0, 5) == 0), $urandom_range(2, 9));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
Runtime-programmable, glitch-free clock divider. It generates a registered divided clock clk_o and a one-cycle tick_o strobe from clk_i, with divisor N loadable at runtime. Divisor changes and enable/disable take effect only at period boundaries. It is the parametrised successor of the fixed divide-by-2 divider and serves as the clock/strobe source for slow peripherals (UART baud, LED scan, debouncers).

Parameters:
WIDTH, 8, width of divisor and internal counter.
DEFAULT_DIV, 2, active divisor after reset; must lie in 2..2^WIDTH-1.

Ports:
clk_i  input  1  system clock; all logic on rising edge.
rst_i  input  1  reset, asynchronous, active-high.
en_i  input  1  run request; level-sensitive.
div_i  input  WIDTH  new divisor value N.
div_load_i  input  1  single-cycle strobe; captures div_i.
clk_o  output  1  divided clock, registered.
tick_o  output  1  one-cycle strobe on each clk_o rising cycle.
running_o  output  1  high while the divider is generating periods.
pending_o  output  1  high while a loaded divisor waits for a boundary.

Behaviour:
- Single clock (clk_i), asynchronous active-high reset (rst_i).
- Reset, asynchronous with immediate effect, no clock edge needed: clk_o=0, tick_o=0, running_o=0, pending_o=0, counter=0, active divisor=DEFAULT_DIV, pending register=DEFAULT_DIV.
- Divisor clamp: captured values 0 and 1 are stored as 2. Legal range is 2..2^WIDTH-1.
- Duty cycle: H=ceil(N/2) high cycles, then N-H low cycles.
  - Even N gives exactly 50%.
  - Odd N gives one extra high cycle. Example: N=255 gives 128 high, 127 low.
- State machine:
  - IDLE: clk_o=0, running_o=0.
  - RUN: counter counts 0..N-1 and wraps.
  - STOPPING: finishes the current period, then returns to IDLE.
- IDLE->RUN: the edge that samples en_i=1 enters RUN. clk_o=1 and tick_o=1 are visible in the cycle after that edge (1-cycle latency).
- Period boundary: the edge at which clk_o goes 0->1. tick_o is high for exactly that first high cycle, so tick_o period = N.
- RUN->STOPPING: en_i sampled 0. The current period completes in full (remaining high cycles plus all N-H low cycles). Then IDLE with clk_o=0; no truncated pulse and no further tick_o.
- en_i sampled 1 again while in STOPPING: cancels the stop and returns to RUN with no phase disturbance.
- Divisor load while running:
  - div_load_i=1 writes the pending register and sets pending_o on the next cycle.
  - At the next boundary, the active divisor takes the pending value, pending_o clears, and the new period uses the new N.
  - The period in progress always completes with the old N.
- Load coinciding with a boundary edge: the period starting at that edge uses the old (or previously pending) N. The new value applies at the following boundary.
- Repeated loads before a boundary: last value wins; pending_o stays 1.
- Load while IDLE: the active divisor updates at that edge and pending_o stays 0. Load plus en_i rise on the same edge: the first period uses the newly loaded N.
- clk_o and tick_o are flop outputs (no combinational path from inputs), so there are no glitches.

Test Plan:
- Reset: rst_i=1 for 2 cycles, then en_i=1 (DEFAULT_DIV=2) -> clk_o pattern 1,0,1,0; tick_o every 2nd cycle coincident with clk_o high; running_o=1. Assert rst_i between edges while clk_o=1 -> all outputs 0 immediately.
- Odd divisor: IDLE, load 5 and enable -> clk_o 3 high / 2 low repeating; tick_o every 5 cycles; pending_o never set.
- Mid-period reload: running N=4, load 7 two cycles after a boundary -> pending_o=1; current period still 4 cycles; next period 4 high / 3 low; pending_o clears at that boundary. Then two loads (9 then 6) in one period -> next period uses 6.
- Clamp and maximum: load 0 -> period 2; load 1 -> period 2; load 255 (WIDTH=8) -> 128 high / 127 low.
- Graceful stop: N=6, drop en_i in the 2nd high cycle -> 1 more high and 3 low cycles, then clk_o held 0, running_o=0, no tick_o. Re-raise en_i during the low phase of a second stop -> running continues seamlessly.
- Boundary collision: load 3 on the exact edge of a clk_o rise while N=4 -> that period is 4 cycles and the following period is 3 (2 high / 1 low).
